miter_vector_driver: RTL and testbench
======================================

Name: miter_vector_driver

Overview:
- Sequential stimulus/response end of the miter flow: drives the shared primary inputs (a, b, c style) into an implementation netlist and a specification netlist.
- Samples both output vectors and compares them bit-for-bit.
- Sweeps all 2^N_IN input combinations exhaustively.
- Reports pass, or the first counterexample vector and which outputs differ; used as the simulation-side cross-check for equivalence-checker results.

Parameters:
- N_IN, 3, number of primary inputs driven (1..16).
- N_OUT, 2, number of compared outputs (y1, y2 style).
- SETTLE, 1, cycles vec_out is held before sampling (1..15; 0 illegal).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured in IDLE or DONE only.
- vec_out  output  N_IN  current input vector to both netlists; bit0 = first input.
- impl_y  input  N_OUT  implementation outputs, combinational from vec_out.
- spec_y  input  N_OUT  specification outputs, combinational from vec_out.
- busy  output  1  high in SETTLE/COMPARE.
- done  output  1  high in DONE, held until start or reset.
- mismatch  output  1  valid with done; 1 = counterexample found.
- cex_vec  output  N_IN  failing vector (valid when mismatch=1).
- cex_diff  output  N_OUT  impl_y ^ spec_y at the failing vector.
- vec_count  output  N_IN+1  number of vectors compared in the current/last sweep.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - vec_out, cex_vec, cex_diff, vec_count all 0.
  - busy, done, mismatch all 0.
  - Reset mid-sweep aborts immediately; no partial result is kept.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE/DONE + start=1:
  - Next state SETTLE.
  - vec_out=0, vec_count=0, wait counter=SETTLE.
  - mismatch, cex_vec and cex_diff cleared.
  - done drops the same edge.
- start while busy: ignored, no effect.
- SETTLE: counter decrements each cycle; after SETTLE cycles go to COMPARE. vec_out is stable throughout.
- COMPARE (one cycle; impl_y/spec_y sampled at the end of this cycle):
  - vec_count increments.
  - If impl_y != spec_y: go to DONE, mismatch=1, cex_vec=vec_out, cex_diff=impl_y^spec_y.
  - Else if vec_out == all-ones: go to DONE, mismatch=0.
  - Else vec_out increments by 1 (no wrap is ever reached), counter reloads to SETTLE, go to SETTLE.
- Latency:
  - Each vector takes SETTLE+1 cycles.
  - A full passing sweep asserts done (2^N_IN)*(SETTLE+1) cycles after the start edge.
- DONE: vec_out holds its last value. start=1 restarts as above. Simultaneous start and reset: reset wins.
- vec_count width N_IN+1 holds 2^N_IN without overflow.

Optional Feature:
- Macro MITER_FULL_SWEEP_EN.
- Defined:
  - A mismatch does not terminate the sweep. The sweep always runs to vector all-ones.
  - cex_vec/cex_diff capture the FIRST mismatch only.
  - Extra output err_count (N_IN+1 bits, reset 0, cleared on start) counts mismatching vectors.
  - mismatch = (err_count != 0) at done.
- Not defined: the sweep halts at the first mismatch as described above, and err_count does not exist.

Test Plan:
- Identical netlists, both computing y1=a&b&(a^c) and y2=(b|c)==0, N_IN=3, SETTLE=1; pulse start -> done=1 exactly 16 cycles later, mismatch=0, vec_count=8, vec_out=3'b111.
- impl y2 forced to ~spec y2 only at vec 3'b101 -> done after 6*2=12 cycles, mismatch=1, cex_vec=3'b101, cex_diff=2'b10, vec_count=6.
- impl y1 stuck-at-1 -> halts at vec 0: cex_vec=0, cex_diff=2'b01, vec_count=1, done 2 cycles after start.
- rst_n=0 asserted in SETTLE at vec 3'b100 -> all outputs 0 asynchronously; a new start resweeps from vec 0.
- start re-pulsed while busy -> no restart, result identical to the undisturbed run. start in DONE -> mismatch cleared, new sweep begins.
- MITER_FULL_SWEEP_EN, impl differs at vecs 2 and 6 -> done after 16 cycles, err_count=2, cex_vec=3'b010, mismatch=1.

Source files
------------

// File: rtl/miter_vector_driver_if.sv
// Stimulus/response bundle between the miter vector driver and the two netlists under comparison.
// err_count is present only when MITER_FULL_SWEEP_EN is defined.
interface miter_vector_driver_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 2
);
   logic              start;
   logic [N_IN-1:0]   vec_out;
   logic [N_OUT-1:0]  impl_y;
   logic [N_OUT-1:0]  spec_y;
   logic              busy;
   logic              done;
   logic              mismatch;
   logic [N_IN-1:0]   cex_vec;
   logic [N_OUT-1:0]  cex_diff;
   logic [N_IN:0]     vec_count;
`ifdef MITER_FULL_SWEEP_EN
   logic [N_IN:0]     err_count;
`endif

   modport master (
`ifdef MITER_FULL_SWEEP_EN
      output err_count,
`endif
      input  start,
      input  impl_y,
      input  spec_y,
      output vec_out,
      output busy,
      output done,
      output mismatch,
      output cex_vec,
      output cex_diff,
      output vec_count
   );

   modport slave (
`ifdef MITER_FULL_SWEEP_EN
      input  err_count,
`endif
      output start,
      output impl_y,
      output spec_y,
      input  vec_out,
      input  busy,
      input  done,
      input  mismatch,
      input  cex_vec,
      input  cex_diff,
      input  vec_count
   );
endinterface

// File: rtl/miter_vector_driver.sv
// Exhaustive miter vector driver: sweeps all 2^N_IN inputs, compares impl_y against spec_y.
// Define MITER_FULL_SWEEP_EN to keep sweeping past mismatches and count them in err_count.
module miter_vector_driver #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   miter_vector_driver_if.master bus
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int                CW         = 4;
   localparam logic [CW-1:0]     CNT_LOAD   = CW'(SETTLE);
   localparam logic [CW-1:0]     CNT_ONE    = 4'd1;
   localparam logic [CW-1:0]     CNT_ZERO   = 4'd0;
   localparam logic [N_IN-1:0]   VEC_ZERO   = {N_IN{1'b0}};
   localparam logic [N_IN-1:0]   VEC_ONE    = N_IN'(1'b1);
   localparam logic [N_IN-1:0]   VEC_ONES   = {N_IN{1'b1}};
   localparam logic [N_OUT-1:0]  DIFF_ZERO  = {N_OUT{1'b0}};
   localparam logic [N_IN:0]     COUNT_ZERO = {(N_IN+1){1'b0}};
   localparam logic [N_IN:0]     COUNT_ONE  = (N_IN+1)'(1'b1);

   state_t            state_q, state_d;
   logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [N_IN-1:0]   cex_vec_q, cex_vec_d;
   logic [N_OUT-1:0]  cex_diff_q, cex_diff_d;
   logic [N_IN:0]     vec_count_q, vec_count_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              mismatch_q, mismatch_d;
   logic [N_OUT-1:0]  diff_s;
`ifdef MITER_FULL_SWEEP_EN
   logic [N_IN:0]     err_count_q, err_count_d;
`endif

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      vec_d       = vec_q;
      cex_vec_d   = cex_vec_q;
      cex_diff_d  = cex_diff_q;
      vec_count_d = vec_count_q;
      mismatch_d  = mismatch_q;
`ifdef MITER_FULL_SWEEP_EN
      err_count_d = err_count_q;
`endif
      diff_s      = bus.impl_y ^ bus.spec_y;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d     = ST_SETTLE;
               wait_cnt_d  = CNT_LOAD;
               vec_d       = VEC_ZERO;
               vec_count_d = COUNT_ZERO;
               mismatch_d  = 1'b0;
               cex_vec_d   = VEC_ZERO;
               cex_diff_d  = DIFF_ZERO;
`ifdef MITER_FULL_SWEEP_EN
               err_count_d = COUNT_ZERO;
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_SETTLE: begin
            if (wait_cnt_q <= CNT_ONE) begin
               state_d    = ST_COMPARE;
               wait_cnt_d = CNT_ZERO;
            end else begin
               wait_cnt_d = wait_cnt_q - CNT_ONE;
            end
         end
         ST_COMPARE: begin
            vec_count_d = vec_count_q + COUNT_ONE;
`ifdef MITER_FULL_SWEEP_EN
            // Only the first failing vector is kept as the counterexample.
            if (diff_s != DIFF_ZERO) begin
               err_count_d = err_count_q + COUNT_ONE;
               if (err_count_q == COUNT_ZERO) begin
                  cex_vec_d  = vec_q;
                  cex_diff_d = diff_s;
               end else begin
                  cex_vec_d  = cex_vec_q;
               end
            end else begin
               err_count_d = err_count_q;
            end
            if (vec_q == VEC_ONES) begin
               state_d    = ST_DONE;
               mismatch_d = (err_count_d != COUNT_ZERO);
            end else begin
               state_d    = ST_SETTLE;
               vec_d      = vec_q + VEC_ONE;
               wait_cnt_d = CNT_LOAD;
            end
`else
            if (diff_s != DIFF_ZERO) begin
               state_d    = ST_DONE;
               mismatch_d = 1'b1;
               cex_vec_d  = vec_q;
               cex_diff_d = diff_s;
            end else if (vec_q == VEC_ONES) begin
               state_d    = ST_DONE;
               mismatch_d = 1'b0;
            end else begin
               state_d    = ST_SETTLE;
               vec_d      = vec_q + VEC_ONE;
               wait_cnt_d = CNT_LOAD;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered from the next state so they line up with it.
      busy_d = (state_d == ST_SETTLE) || (state_d == ST_COMPARE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= CNT_ZERO;
         vec_q       <= VEC_ZERO;
         cex_vec_q   <= VEC_ZERO;
         cex_diff_q  <= DIFF_ZERO;
         vec_count_q <= COUNT_ZERO;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mismatch_q  <= 1'b0;
`ifdef MITER_FULL_SWEEP_EN
         err_count_q <= COUNT_ZERO;
`endif
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         vec_q       <= vec_d;
         cex_vec_q   <= cex_vec_d;
         cex_diff_q  <= cex_diff_d;
         vec_count_q <= vec_count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mismatch_q  <= mismatch_d;
`ifdef MITER_FULL_SWEEP_EN
         err_count_q <= err_count_d;
`endif
      end
   end

   assign bus.vec_out   = vec_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.mismatch  = mismatch_q;
   assign bus.cex_vec   = cex_vec_q;
   assign bus.cex_diff  = cex_diff_q;
   assign bus.vec_count = vec_count_q;
`ifdef MITER_FULL_SWEEP_EN
   assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_miter_vector_driver.sv
// Bench for miter_vector_driver: directed and randomized fault tables on a small 3-input miter,
// checked against a sweep-level reference model.
`timescale 1ns/1ps
module tb_miter_vector_driver;
   localparam int N_IN   = 3;
   localparam int N_OUT  = 2;
   localparam int SETTLE = 1;
   localparam int NV     = 1 << N_IN;
   localparam int BUDGET = 400;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [N_OUT-1:0] fault_tab [NV];
   logic [N_OUT-1:0] stuck1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   int          e_cnt, e_err, e_lat;
   logic        e_mis;
   logic [31:0] e_cex, e_diff, e_last;

   miter_vector_driver_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

   miter_vector_driver #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference netlist: bit0 = y1 = a&b&(a^c), bit1 = y2 = (b|c)==0; a=bit0, b=bit1, c=bit2.
   function automatic logic [N_OUT-1:0] spec_fn(input logic [N_IN-1:0] v);
      logic a, b, c;
      a = v[0];
      b = v[1];
      c = v[2];
      return {~(b | c), a & b & (a ^ c)};
   endfunction

   assign bus.spec_y = spec_fn(bus.vec_out);
   assign bus.impl_y = (spec_fn(bus.vec_out) ^ fault_tab[bus.vec_out]) | stuck1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_faults();
      for (int v = 0; v < NV; v++) fault_tab[v] = '0;
      stuck1 = '0;
   endtask

   // Predict the whole sweep outcome by walking the vector space in order.
   task automatic predict();
      logic [N_OUT-1:0] d;
      e_cnt = 0; e_err = 0; e_mis = 1'b0;
      e_cex = 0; e_diff = 0; e_last = 0;
      for (int v = 0; v < NV; v++) begin
         d = ((spec_fn(N_IN'(v)) ^ fault_tab[v]) | stuck1) ^ spec_fn(N_IN'(v));
         e_cnt++;
         e_last = 32'(v);
         if (d != '0) begin
            if (e_err == 0) begin
               e_cex  = 32'(v);
               e_diff = 32'(d);
            end
            e_err++;
            e_mis = 1'b1;
`ifndef MITER_FULL_SWEEP_EN
            break;
`endif
         end
      end
      e_lat = e_cnt * (SETTLE + 1);
   endtask

   task automatic run_sweep(input string tag, input int repulse_at);
      int n;
      predict();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check({tag, ":busy_at_start"},     32'(bus.busy),      32'd1);
      check({tag, ":done_dropped"},      32'(bus.done),      32'd0);
      check({tag, ":mismatch_cleared"},  32'(bus.mismatch),  32'd0);
      check({tag, ":count_cleared"},     32'(bus.vec_count), 32'd0);
      check({tag, ":vec_from_zero"},     32'(bus.vec_out),   32'd0);
      n = 0;
      while (bus.done !== 1'b1 && n < BUDGET) begin
         @(posedge clk);
         n++;
         #1;
         if (n == repulse_at && bus.done !== 1'b1) begin
            bus.start = 1'b1;
            @(posedge clk);
            n++;
            #1 bus.start = 1'b0;
         end
      end
      check({tag, ":latency"},  32'(n),             32'(e_lat));
      check({tag, ":done"},     32'(bus.done),      32'd1);
      check({tag, ":busy_end"}, 32'(bus.busy),      32'd0);
      check({tag, ":mismatch"}, 32'(bus.mismatch),  32'(e_mis));
      check({tag, ":cex_vec"},  32'(bus.cex_vec),   e_cex);
      check({tag, ":cex_diff"}, 32'(bus.cex_diff),  e_diff);
      check({tag, ":count"},    32'(bus.vec_count), 32'(e_cnt));
      check({tag, ":vec_hold"}, 32'(bus.vec_out),   e_last);
`ifdef MITER_FULL_SWEEP_EN
      check({tag, ":err_count"}, 32'(bus.err_count), 32'(e_err));
`endif
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ":vec_out"},   32'(bus.vec_out),   32'd0);
      check({tag, ":busy"},      32'(bus.busy),      32'd0);
      check({tag, ":done"},      32'(bus.done),      32'd0);
      check({tag, ":mismatch"},  32'(bus.mismatch),  32'd0);
      check({tag, ":cex_vec"},   32'(bus.cex_vec),   32'd0);
      check({tag, ":cex_diff"},  32'(bus.cex_diff),  32'd0);
      check({tag, ":vec_count"}, 32'(bus.vec_count), 32'd0);
`ifdef MITER_FULL_SWEEP_EN
      check({tag, ":err_count"}, 32'(bus.err_count), 32'd0);
`endif
   endtask

   initial begin
      int n;
      bus.start = 1'b0;
      clear_faults();

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("idle");

      // Identical netlists: full passing sweep.
      run_sweep("equiv", 0);

      // y2 inverted at vector 5; DONE state also exercises restart-from-done next.
      clear_faults();
      fault_tab[5] = 2'b10;
      run_sweep("y2_at_5", 0);

      // y1 stuck-at-1 fails immediately at vector 0.
      clear_faults();
      stuck1 = 2'b01;
      run_sweep("y1_stuck1", 0);

      // Restart from DONE with clean netlists; mismatch must clear.
      clear_faults();
      run_sweep("restart_done", 0);

      // start re-pulsed while busy must not disturb the sweep.
      fault_tab[5] = 2'b10;
      run_sweep("repulse_busy", 5);

      // Async reset while settling vector 4, then a fresh sweep from 0.
      clear_faults();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      while (bus.vec_out !== 3'd4 && n < BUDGET) begin
         @(posedge clk);
         n++;
         #1;
      end
      check("rst_mid:at_vec4", 32'(bus.vec_out), 32'd4);
      check("rst_mid:busy",    32'(bus.busy),    32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep("after_rst", 0);

      // Mismatches at vectors 2 and 6.
      clear_faults();
      fault_tab[2] = 2'b01;
      fault_tab[6] = 2'b11;
      run_sweep("two_faults", 0);

      // Randomized fault tables.
      for (int it = 0; it < 8; it++) begin
         clear_faults();
         for (int v = 0; v < NV; v++) begin
            if ($urandom_range(0, 4) == 0) fault_tab[v] = N_OUT'($urandom_range(1, (1 << N_OUT) - 1));
         end
         run_sweep($sformatf("rand%0d", it), int'($urandom_range(0, 4)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
